// File: rtl/equation_pkg.sv
// Shared types, widths and the saturating arithmetic used by the equation evaluator.
//   state_t   : evaluator FSM states
//   op_t      : latched operator (OP_PLUS, OP_MINUS)
//   VAL_W     : width of a number sprite value
//   ACC_W     : width of the signed running equation value
//   ACC_MAX/ACC_MIN : saturation limits of the running value
//   apply_op  : acc +/- zero-extended value, clamped to [ACC_MIN, ACC_MAX]
package equation_pkg;

   localparam int VAL_W = 4;
   localparam int ACC_W = 8;

   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [2:0] {
      WAIT_NUM,
      WAIT_OP,
      EVAL,
      HOLD,
      OVER
   } state_t;

   typedef enum logic {
      OP_PLUS,
      OP_MINUS
   } op_t;

   // Two guard bits are enough: |acc| <= 128 and val <= 15.
   function automatic logic signed [ACC_W-1:0] apply_op(
      input logic signed [ACC_W-1:0] acc,
      input logic [VAL_W-1:0]        val,
      input op_t                     op
   );
      logic signed [ACC_W+1:0] wide_acc;
      logic signed [ACC_W+1:0] wide_val;
      logic signed [ACC_W+1:0] wide_res;
      logic signed [ACC_W+1:0] wide_max;
      logic signed [ACC_W+1:0] wide_min;
      wide_acc = {{2{acc[ACC_W-1]}}, acc};
      wide_val = {{(ACC_W+2-VAL_W){1'b0}}, val};
      wide_max = {{3{1'b0}}, {(ACC_W-1){1'b1}}};
      wide_min = {{3{1'b1}}, {(ACC_W-1){1'b0}}};
      if (op == OP_MINUS) wide_res = wide_acc - wide_val;
      else                wide_res = wide_acc + wide_val;
      if (wide_res > wide_max)      apply_op = ACC_MAX;
      else if (wide_res < wide_min) apply_op = ACC_MIN;
      else                          apply_op = wide_res[ACC_W-1:0];
   endfunction

endpackage

// File: rtl/hit_priority_encoder.sv
// Reduces the per-sprite hit pulse vector to a valid flag and the lowest set index.
//   hit   : one-hot-ish collision pulses, one bit per number sprite
//   valid : any bit of hit set
//   idx   : index of the lowest set bit (0 when none set)
module hit_priority_encoder #(
   parameter int NUMBERS = 3,
   parameter int IDX_W   = (NUMBERS > 1) ? $clog2(NUMBERS) : 1
) (
   input  logic [NUMBERS-1:0] hit,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);

   // Scanning downward lets the lowest set bit overwrite any higher one.
   always_comb begin
      valid = |hit;
      idx   = '0;
      for (int i = NUMBERS - 1; i >= 0; i--) begin
         if (hit[i]) idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/equation_evaluator.sv
// Game equation evaluator: collects number/operator hits into a signed running value,
// compares it against the target, and tracks score, lives and game over.
//   clk, resetN        : clock, async active-low reset
//   startOfFrame       : one pulse per video frame (paces the result hold)
//   numberHit/Value    : number sprite collision pulses and their 4-bit values
//   operandHit         : bit0 plus, bit1 minus collision pulses
//   targetValue        : signed target of the current equation
//   newGame            : restart score, lives and equation
//   accValue/termCount : running value and numbers consumed
//   score/lives        : equations solved, remaining lives
//   winPulse/losePulse : one-cycle result pulses
//   expectOperand      : next valid hit is an operand
//   gameOver           : sticky, lives exhausted
//
// state    | meaning
// WAIT_NUM | waiting for a number hit
// WAIT_OP  | waiting for an operand hit
// EVAL     | one cycle: compare value against target / term limit
// HOLD     | result shown for HOLD_FRAMES frames
// OVER     | no lives left, waits for newGame
module equation_evaluator
   import equation_pkg::*;
#(
   parameter int NUMBERS     = 3,
   parameter int MAX_TERMS   = 4,
   parameter int HOLD_FRAMES = 60,
   parameter int START_LIVES = 3
) (
   input  logic                          clk,
   input  logic                          resetN,
   input  logic                          startOfFrame,
   input  logic [NUMBERS-1:0]            numberHit,
   input  logic [NUMBERS-1:0][VAL_W-1:0] numberValue,
   input  logic [1:0]                    operandHit,
   input  logic signed [ACC_W-1:0]       targetValue,
   input  logic                          newGame,
   output logic signed [ACC_W-1:0]       accValue,
   output logic [2:0]                    termCount,
   output logic [7:0]                    score,
   output logic [1:0]                    lives,
   output logic                          winPulse,
   output logic                          losePulse,
   output logic                          expectOperand,
   output logic                          gameOver
);

   localparam int IDX_W   = (NUMBERS > 1) ? $clog2(NUMBERS) : 1;
   localparam int TERM_W  = ($clog2(MAX_TERMS + 1) > 3) ? $clog2(MAX_TERMS + 1) : 3;
   localparam int FRAME_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;

   state_t                  state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [TERM_W-1:0]       term_q, term_d;
   op_t                     op_q, op_d;
   logic [7:0]              score_q, score_d;
   logic [1:0]              lives_q, lives_d;
   logic [FRAME_W-1:0]      frame_q, frame_d;
   logic                    win_q, win_d;
   logic                    lose_q, lose_d;
   logic                    over_q, over_d;
   logic                    expop_q, expop_d;

   logic                    hit_valid;
   logic [IDX_W-1:0]        hit_idx;
   logic [VAL_W-1:0]        hit_val;

   hit_priority_encoder #(
      .NUMBERS (NUMBERS),
      .IDX_W   (IDX_W)
   ) u_hit_enc (
      .hit   (numberHit),
      .valid (hit_valid),
      .idx   (hit_idx)
   );

   assign hit_val = numberValue[hit_idx];

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= WAIT_NUM;
         acc_q   <= '0;
         term_q  <= '0;
         op_q    <= OP_PLUS;
         score_q <= '0;
         lives_q <= 2'(START_LIVES);
         frame_q <= '0;
         win_q   <= 1'b0;
         lose_q  <= 1'b0;
         over_q  <= 1'b0;
         expop_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         term_q  <= term_d;
         op_q    <= op_d;
         score_q <= score_d;
         lives_q <= lives_d;
         frame_q <= frame_d;
         win_q   <= win_d;
         lose_q  <= lose_d;
         over_q  <= over_d;
         expop_q <= expop_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      term_d  = term_q;
      op_d    = op_q;
      score_d = score_q;
      lives_d = lives_q;
      frame_d = frame_q;
      win_d   = 1'b0;
      lose_d  = 1'b0;
      over_d  = over_q;

      if (newGame) begin
         state_d = WAIT_NUM;
         acc_d   = '0;
         term_d  = '0;
         op_d    = OP_PLUS;
         score_d = '0;
         lives_d = 2'(START_LIVES);
         frame_d = '0;
         over_d  = 1'b0;
      end else begin
         case (state_q)
            WAIT_NUM: begin
               if (hit_valid) begin
                  if (term_q == '0) acc_d = {{(ACC_W-VAL_W){1'b0}}, hit_val};
                  else              acc_d = apply_op(acc_q, hit_val, op_q);
                  term_d  = term_q + TERM_W'(1);
                  state_d = EVAL;
               end
            end
            WAIT_OP: begin
               if (operandHit[0]) begin
                  op_d    = OP_PLUS;
                  state_d = WAIT_NUM;
               end else if (operandHit[1]) begin
                  op_d    = OP_MINUS;
                  state_d = WAIT_NUM;
               end
            end
            EVAL: begin
               if (acc_q == targetValue) begin
                  win_d   = 1'b1;
                  if (score_q != 8'hFF) score_d = score_q + 8'd1;
                  frame_d = FRAME_W'(HOLD_FRAMES);
                  state_d = HOLD;
               end else if (term_q == TERM_W'(MAX_TERMS)) begin
                  lose_d  = 1'b1;
                  if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
                  frame_d = FRAME_W'(HOLD_FRAMES);
                  state_d = HOLD;
               end else begin
                  state_d = WAIT_OP;
               end
            end
            HOLD: begin
               if (startOfFrame) begin
                  // <= 1 so a zero hold length still releases after one frame
                  if (frame_q <= FRAME_W'(1)) begin
                     frame_d = '0;
                     acc_d   = '0;
                     term_d  = '0;
                     op_d    = OP_PLUS;
                     if (lives_q == 2'd0) begin
                        state_d = OVER;
                        over_d  = 1'b1;
                     end else begin
                        state_d = WAIT_NUM;
                     end
                  end else begin
                     frame_d = frame_q - FRAME_W'(1);
                  end
               end
            end
            OVER: begin
               over_d = 1'b1;
            end
            default: begin
               state_d = WAIT_NUM;
            end
         endcase
      end

      expop_d = (state_d == WAIT_OP);
   end

   assign accValue      = acc_q;
   // Counter may be wider than the 3-bit port for long equations; saturate the view.
   assign termCount     = (|(term_q >> 3)) ? 3'd7 : term_q[2:0];
   assign score         = score_q;
   assign lives         = lives_q;
   assign winPulse      = win_q;
   assign losePulse     = lose_q;
   assign expectOperand = expop_q;
   assign gameOver      = over_q;

endmodule

// File: tb/tb_equation_evaluator.sv
module tb_equation_evaluator;

   logic              clk;
   logic              resetN;
   logic              startOfFrame;
   logic [2:0]        numberHit;
   logic [2:0]        sat_hit;
   logic [2:0][3:0]   numberValue;
   logic [1:0]        operandHit;
   logic signed [7:0] targetValue;
   logic              newGame;

   logic signed [7:0] accValue;
   logic [2:0]        termCount;
   logic [7:0]        score;
   logic [1:0]        lives;
   logic              winPulse, losePulse, expectOperand, gameOver;

   logic signed [7:0] s_accValue;
   logic [2:0]        s_termCount;
   logic [7:0]        s_score;
   logic [1:0]        s_lives;
   logic              s_winPulse, s_losePulse, s_expectOperand, s_gameOver;

   int errors = 0;
   int checks = 0;

   int m_acc, m_term, m_score, m_lives;
   bit m_minus;
   int acc_q[$];
   int res_q[$];

   equation_evaluator #(
      .NUMBERS(3), .MAX_TERMS(4), .HOLD_FRAMES(2), .START_LIVES(3)
   ) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .numberHit(numberHit), .numberValue(numberValue), .operandHit(operandHit),
      .targetValue(targetValue), .newGame(newGame),
      .accValue(accValue), .termCount(termCount), .score(score), .lives(lives),
      .winPulse(winPulse), .losePulse(losePulse),
      .expectOperand(expectOperand), .gameOver(gameOver)
   );

   equation_evaluator #(
      .NUMBERS(3), .MAX_TERMS(15), .HOLD_FRAMES(2), .START_LIVES(3)
   ) dut_sat (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .numberHit(sat_hit), .numberValue(numberValue), .operandHit(operandHit),
      .targetValue(targetValue), .newGame(newGame),
      .accValue(s_accValue), .termCount(s_termCount), .score(s_score), .lives(s_lives),
      .winPulse(s_winPulse), .losePulse(s_losePulse),
      .expectOperand(s_expectOperand), .gameOver(s_gameOver)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic int sat_ref(input int a, input int v, input bit minus);
      int r;
      r = minus ? a - v : a + v;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      return r;
   endfunction

   task automatic num_hit(input logic [2:0] mask, input logic [3:0] v0, v1, v2);
      int val, want_res, got_res, want_acc;
      val = mask[0] ? int'(v0) : (mask[1] ? int'(v1) : int'(v2));
      m_acc = (m_term == 0) ? val : sat_ref(m_acc, val, m_minus);
      m_term++;
      acc_q.push_back(m_acc);
      if (m_acc == int'(targetValue)) begin
         want_res = 1;
         if (m_score < 255) m_score++;
      end else if (m_term == 4) begin
         want_res = 2;
         if (m_lives > 0) m_lives--;
      end else begin
         want_res = 0;
      end
      res_q.push_back(want_res);
      @(negedge clk);
      numberHit = mask;
      numberValue = {v2, v1, v0};
      @(negedge clk);
      numberHit = '0;
      want_acc = acc_q.pop_front();
      checks++;
      if (accValue !== 8'(want_acc)) begin
         errors++;
         $display("FAIL num_acc: got %0d expected %0d", accValue, want_acc);
      end
      checks++;
      if (termCount !== 3'(m_term)) begin
         errors++;
         $display("FAIL num_term: got %0d expected %0d", termCount, m_term);
      end
      @(negedge clk);
      want_res = res_q.pop_front();
      got_res = {30'd0, losePulse, winPulse};
      checks++;
      if (got_res !== want_res) begin
         errors++;
         $display("FAIL result_pulse: got %0d expected %0d (1=win 2=lose)", got_res, want_res);
      end
      checks++;
      if (score !== 8'(m_score) || lives !== 2'(m_lives)) begin
         errors++;
         $display("FAIL score_lives: got %0d/%0d expected %0d/%0d", score, lives, m_score, m_lives);
      end
      checks++;
      if (expectOperand !== (want_res == 0)) begin
         errors++;
         $display("FAIL expect_op_after_eval: got %0b expected %0b", expectOperand, want_res == 0);
      end
   endtask

   task automatic op_hit(input logic [1:0] mask);
      @(negedge clk);
      operandHit = mask;
      @(negedge clk);
      operandHit = '0;
      m_minus = !mask[0];
      checks++;
      if (expectOperand !== 1'b0) begin
         errors++;
         $display("FAIL op_taken: expectOperand got %0b expected 0", expectOperand);
      end
   endtask

   task automatic sof_pulse();
      @(negedge clk);
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
   endtask

   task automatic do_hold();
      sof_pulse();
      checks++;
      if (accValue !== 8'(m_acc)) begin
         errors++;
         $display("FAIL hold_keep: acc got %0d expected %0d", accValue, m_acc);
      end
      sof_pulse();
      m_acc = 0;
      m_term = 0;
      m_minus = 0;
      checks++;
      if (accValue !== 8'sd0 || termCount !== 3'd0) begin
         errors++;
         $display("FAIL hold_clear: acc/term got %0d/%0d expected 0/0", accValue, termCount);
      end
      checks++;
      if (gameOver !== (m_lives == 0)) begin
         errors++;
         $display("FAIL hold_gameover: got %0b expected %0b", gameOver, m_lives == 0);
      end
   endtask

   task automatic loss_eq();
      targetValue = 8'sd100;
      num_hit(3'b001, 4'd1, 4'd0, 4'd0);
      op_hit(2'b01);
      num_hit(3'b001, 4'd1, 4'd0, 4'd0);
      op_hit(2'b01);
      num_hit(3'b001, 4'd1, 4'd0, 4'd0);
      op_hit(2'b01);
      num_hit(3'b001, 4'd1, 4'd0, 4'd0);
      do_hold();
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (accValue !== 8'sd0 || termCount !== 3'd0 || score !== 8'd0) begin
         errors++;
         $display("FAIL reset_acc_term_score: got %0d/%0d/%0d expected 0/0/0", accValue, termCount, score);
      end
      checks++;
      if (lives !== 2'd3 || gameOver !== 1'b0) begin
         errors++;
         $display("FAIL reset_lives_over: got %0d/%0b expected 3/0", lives, gameOver);
      end
      checks++;
      if (winPulse !== 1'b0 || losePulse !== 1'b0 || expectOperand !== 1'b0) begin
         errors++;
         $display("FAIL reset_pulses: got %0b%0b%0b expected 000", winPulse, losePulse, expectOperand);
      end
      resetN = 1'b1;
      @(negedge clk);
      m_acc = 0; m_term = 0; m_score = 0; m_lives = 3; m_minus = 0;
   endtask

   task automatic test_win_basic();
      targetValue = 8'sd7;
      num_hit(3'b001, 4'd3, 4'd0, 4'd0);
      op_hit(2'b01);
      num_hit(3'b010, 4'd0, 4'd4, 4'd0);
      do_hold();
   endtask

   task automatic test_minus_and_loss();
      targetValue = -8'sd5;
      num_hit(3'b001, 4'd2, 4'd0, 4'd0);
      op_hit(2'b10);
      num_hit(3'b100, 4'd0, 4'd0, 4'd7);
      do_hold();
      targetValue = 8'sd0;
      num_hit(3'b001, 4'd15, 4'd0, 4'd0);
      for (int i = 0; i < 3; i++) begin
         op_hit(2'b01);
         num_hit(3'b001, 4'd15, 4'd0, 4'd0);
      end
      do_hold();
   endtask

   task automatic test_priority();
      targetValue = 8'sd100;
      num_hit(3'b110, 4'd9, 4'd5, 4'd0);
      @(negedge clk);
      numberHit = 3'b001;
      numberValue = {4'd0, 4'd0, 4'd9};
      @(negedge clk);
      numberHit = '0;
      @(negedge clk);
      checks++;
      if (accValue !== 8'(m_acc) || termCount !== 3'(m_term) || expectOperand !== 1'b1) begin
         errors++;
         $display("FAIL num_in_wait_op: acc/term/expop got %0d/%0d/%0b expected %0d/%0d/1",
                  accValue, termCount, expectOperand, m_acc, m_term);
      end
      op_hit(2'b11);
      num_hit(3'b001, 4'd3, 4'd0, 4'd0);
      op_hit(2'b10);
      num_hit(3'b001, 4'd1, 4'd0, 4'd0);
      op_hit(2'b01);
      num_hit(3'b001, 4'd2, 4'd0, 4'd0);
      do_hold();
   endtask

   task automatic test_game_over();
      @(negedge clk);
      newGame = 1'b1;
      @(negedge clk);
      newGame = 1'b0;
      m_lives = 3; m_score = 0;
      checks++;
      if (lives !== 2'd3 || score !== 8'd0) begin
         errors++;
         $display("FAIL newgame_restore: lives/score got %0d/%0d expected 3/0", lives, score);
      end
      for (int i = 0; i < 3; i++) loss_eq();
      @(negedge clk);
      numberHit = 3'b001;
      numberValue = {4'd0, 4'd0, 4'd7};
      operandHit = 2'b01;
      @(negedge clk);
      numberHit = '0;
      operandHit = '0;
      sof_pulse();
      checks++;
      if (accValue !== 8'sd0 || termCount !== 3'd0 || gameOver !== 1'b1 || lives !== 2'd0) begin
         errors++;
         $display("FAIL over_ignores_hits: acc/term/over/lives got %0d/%0d/%0b/%0d expected 0/0/1/0",
                  accValue, termCount, gameOver, lives);
      end
      @(negedge clk);
      newGame = 1'b1;
      numberHit = 3'b001;
      numberValue = {4'd0, 4'd0, 4'd6};
      @(negedge clk);
      newGame = 1'b0;
      numberHit = '0;
      m_lives = 3; m_score = 0; m_acc = 0; m_term = 0; m_minus = 0;
      checks++;
      if (lives !== 2'd3 || score !== 8'd0 || gameOver !== 1'b0) begin
         errors++;
         $display("FAIL newgame_after_over: lives/score/over got %0d/%0d/%0b expected 3/0/0",
                  lives, score, gameOver);
      end
      checks++;
      if (accValue !== 8'sd0 || termCount !== 3'd0) begin
         errors++;
         $display("FAIL newgame_priority: acc/term got %0d/%0d expected 0/0", accValue, termCount);
      end
      targetValue = 8'sd100;
      num_hit(3'b001, 4'd5, 4'd0, 4'd0);
   endtask

   task automatic test_saturation();
      int s_acc, want_acc;
      int s_res[$];
      int want_res, got_res;
      s_acc = 0;
      for (int t = 0; t < 10; t++) begin
         if (t > 0) begin
            @(negedge clk);
            operandHit = 2'b01;
            @(negedge clk);
            operandHit = '0;
         end
         targetValue = (t == 9) ? 8'sd127 : 8'sd0;
         s_acc = (t == 0) ? 15 : sat_ref(s_acc, 15, 1'b0);
         acc_q.push_back(s_acc);
         s_res.push_back((s_acc == int'(targetValue)) ? 1 : 0);
         @(negedge clk);
         sat_hit = 3'b001;
         numberValue = {4'd0, 4'd0, 4'd15};
         @(negedge clk);
         sat_hit = '0;
         want_acc = acc_q.pop_front();
         checks++;
         if (s_accValue !== 8'(want_acc)) begin
            errors++;
            $display("FAIL sat_acc term %0d: got %0d expected %0d", t + 1, s_accValue, want_acc);
         end
         @(negedge clk);
         want_res = s_res.pop_front();
         got_res = {30'd0, s_losePulse, s_winPulse};
         checks++;
         if (got_res !== want_res) begin
            errors++;
            $display("FAIL sat_result term %0d: got %0d expected %0d", t + 1, got_res, want_res);
         end
      end
      checks++;
      if (s_accValue !== 8'sd127 || s_score !== 8'd1) begin
         errors++;
         $display("FAIL sat_final: acc/score got %0d/%0d expected 127/1", s_accValue, s_score);
      end
      sof_pulse();
      @(negedge clk);
      resetN = 1'b0;
      #1;
      checks++;
      if (s_accValue !== 8'sd0 || s_termCount !== 3'd0 || s_score !== 8'd0 || s_lives !== 2'd3) begin
         errors++;
         $display("FAIL reset_in_hold: acc/term/score/lives got %0d/%0d/%0d/%0d expected 0/0/0/3",
                  s_accValue, s_termCount, s_score, s_lives);
      end
      checks++;
      if (s_winPulse !== 1'b0 || s_gameOver !== 1'b0 || s_expectOperand !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_hold_flags: got %0b%0b%0b expected 000",
                  s_winPulse, s_gameOver, s_expectOperand);
      end
      checks++;
      if (accValue !== 8'sd0 || termCount !== 3'd0 || expectOperand !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_equation: acc/term/expop got %0d/%0d/%0b expected 0/0/0",
                  accValue, termCount, expectOperand);
      end
      @(negedge clk);
      resetN = 1'b1;
      targetValue = 8'sd100;
      @(negedge clk);
      sat_hit = 3'b001;
      numberValue = {4'd0, 4'd0, 4'd4};
      @(negedge clk);
      sat_hit = '0;
      checks++;
      if (s_accValue !== 8'sd4 || s_termCount !== 3'd1) begin
         errors++;
         $display("FAIL after_reset_fresh: acc/term got %0d/%0d expected 4/1", s_accValue, s_termCount);
      end
   endtask

   initial begin
      startOfFrame = 1'b0;
      numberHit    = '0;
      sat_hit      = '0;
      numberValue  = '0;
      operandHit   = '0;
      targetValue  = '0;
      newGame      = 1'b0;
      resetN       = 1'b0;
      test_reset();
      test_win_basic();
      test_minus_and_loss();
      test_priority();
      test_game_over();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
